switch_allocator: RTL and testbench
===================================

SWITCH_ALLOCATOR -- requirements
Module: switch_allocator

Interface
REQ-001 Parameters SHALL be none; port count fixed at 5, matching the 5x5 crossbar select format.
REQ-002 clk  input  1  sole clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req0..req4  input  5 each  one-hot output-port request of input port i (bit j = wants output j); 5'b00000 = idle.
REQ-005 tail  input  5  tail[i]=1 marks the flit presented on input i as the last flit of its packet.
REQ-006 sel0..sel4  output reg  5 each  one-hot input select for crossbar output j (bit i = route input i); 5'b00000 = no grant.
REQ-007 gnt  output reg  5  gnt[i]=1 means input i's flit is switched this cycle.
REQ-008 busy  output reg  5  busy[j]=1 means output j is locked to a packet in progress.

Function
REQ-009 Each output j SHALL arbitrate independently among inputs i with req_i[j]=1.
REQ-010 A req_i with more than one bit set SHALL be treated as idle (no request) for all outputs.
REQ-011 sel_j, gnt and busy SHALL be registered: requests sampled at edge N produce sel/gnt valid after edge N (1-cycle latency), no combinational path from inputs to outputs.
REQ-012 Per-output round-robin pointer ptr_j (3 bits, range 0..4) SHALL give priority order ptr_j, ptr_j+1, ... modulo 5 (4 wraps to 0).
REQ-013 On a new grant to input w, ptr_j SHALL become (w+1) mod 5; with no grant ptr_j SHALL hold.
REQ-014 gnt[i] SHALL equal the OR of sel_j[i] over all j; at most one bit per sel_j SHALL be set.
REQ-015 No requests to output j SHALL give sel_j=5'b00000, never X.
REQ-016 (lock) A grant to input w with tail[w]=0 SHALL set busy[j] and lock output j to w.
REQ-017 (lock) While locked, sel_j SHALL be onehot(w) in cycles where req_w[j]=1 and 5'b00000 otherwise; other requesters SHALL be denied; ptr_j SHALL hold.
REQ-018 (lock) A grant to locked input w with tail[w]=1 SHALL clear busy[j]; new arbitration SHALL start the following cycle.
REQ-019 A single-flit packet (tail=1 at first grant) SHALL be granted without setting busy.
REQ-020 Tail release and a competing request in the same cycle: competitor SHALL be arbitrable no earlier than the next cycle.

Reset
REQ-021 rst=1 at a posedge SHALL clear sel0..sel4, gnt, busy to 0, all ptr_j to 0 and all locks, including mid-packet.
REQ-022 The first arbitration after reset release SHALL use ptr_j=0 (input 0 highest priority).

Configuration
REQ-023 Macro SWALLOC_WORMHOLE_LOCK_EN defined: REQ-016..REQ-018 in force, busy reflects locks.
REQ-024 Macro SWALLOC_WORMHOLE_LOCK_EN undefined: every cycle is a fresh per-flit round-robin arbitration per REQ-012/013, tail ignored, busy tied to 5'b00000.

Verification
REQ-025 Reset, then req0=req1=req2=5'b00100, tail=5'b11111 for 3 cycles -> sel2 = 00001, 00010, 00100 on successive cycles; gnt matches.
REQ-026 req4=5'b00001 alone, then req0=req4=5'b00001 -> sel0=10000, then sel0=00001 (pointer wrapped 4->0).
REQ-027 (lock) req1=5'b01000 tail=0 for 3 flits, req3=5'b01000 concurrently, tail[1]=1 on flit 3 -> sel3=00010 x3, busy[3]=1 until tail; next cycle sel3=01000.
REQ-028 req0=5'b00011 (malformed) with req2=5'b00001 -> sel0=00100, sel1=00000, gnt[0]=0.
REQ-029 rst=1 while output 3 locked to input 1 -> next cycle sel3=0, busy=0; after release req2=req1=5'b01000 -> sel3=00010.
REQ-030 All five inputs to distinct outputs (req_i=onehot(i)) -> sel_i=onehot(i), gnt=5'b11111 in the same cycle.

Source files
------------

// File: rtl/switch_allocator_if.sv
// Request/grant bundle between input ports and the switch allocator.
// The master drives requests and tail flags; the slave returns selects, grants and locks.
interface switch_allocator_if;
    logic [4:0] req0;
    logic [4:0] req1;
    logic [4:0] req2;
    logic [4:0] req3;
    logic [4:0] req4;
    logic [4:0] tail;
    logic [4:0] sel0;
    logic [4:0] sel1;
    logic [4:0] sel2;
    logic [4:0] sel3;
    logic [4:0] sel4;
    logic [4:0] gnt;
    logic [4:0] busy;

    modport master (
        output req0, req1, req2, req3, req4, tail,
        input  sel0, sel1, sel2, sel3, sel4, gnt, busy
    );

    modport slave (
        input  req0, req1, req2, req3, req4, tail,
        output sel0, sel1, sel2, sel3, sel4, gnt, busy
    );
endinterface

// File: rtl/switch_allocator.sv
// 5x5 switch allocator: independent round-robin arbiter per output, registered grants.
// Define SWALLOC_WORMHOLE_LOCK_EN to hold an output for a packet until its tail flit.
module switch_allocator (
    input  logic              clk,
    input  logic              rst,
    switch_allocator_if.slave bus
);
    typedef enum logic {
        S_FREE,
        S_LOCK
    } lock_e;

    logic [4:0] req [5];
    logic [4:0] vld;
    logic [4:0] cand [5];
    logic [4:0] sel_q [5];
    logic [4:0] sel_d [5];
    logic [2:0] ptr_q [5];
    logic [2:0] ptr_d [5];
    logic [4:0] gnt_q;
    logic [4:0] gnt_d;
    logic [3:0] pick [5];

    function automatic logic [2:0] wrap_inc(input logic [2:0] v);
        return (v >= 3'd4) ? 3'd0 : v + 3'd1;
    endfunction

    function automatic logic [4:0] onehot(input logic [2:0] w);
        return 5'd1 << w;
    endfunction

    // {found, index} of first candidate at or after p, wrapping 4 -> 0
    function automatic logic [3:0] rr_pick(
        input logic [4:0] c,
        input logic [2:0] p
    );
        logic [2:0] idx;
        logic [3:0] res;
        idx = p;
        res = '0;
        for (int k = 0; k < 5; k++) begin
            if (!res[3] && c[idx]) begin
                res = {1'b1, idx};
            end
            idx = wrap_inc(idx);
        end
        return res;
    endfunction

    assign req[0] = bus.req0;
    assign req[1] = bus.req1;
    assign req[2] = bus.req2;
    assign req[3] = bus.req3;
    assign req[4] = bus.req4;

    // Multi-hot requests are malformed and dropped entirely
    always_comb begin
        for (int i = 0; i < 5; i++) begin
            vld[i] = (req[i] != 5'd0) && ((req[i] & (req[i] - 5'd1)) == 5'd0);
        end
        for (int j = 0; j < 5; j++) begin
            cand[j] = '0;
            for (int i = 0; i < 5; i++) begin
                cand[j][i] = vld[i] & req[i][j];
            end
            pick[j] = rr_pick(cand[j], ptr_q[j]);
        end
    end

`ifdef SWALLOC_WORMHOLE_LOCK_EN
    lock_e      state_q [5];
    lock_e      state_d [5];
    logic [2:0] own_q [5];
    logic [2:0] own_d [5];
    logic [4:0] busy_w;

    always_comb begin
        for (int j = 0; j < 5; j++) begin
            sel_d[j]   = '0;
            ptr_d[j]   = ptr_q[j];
            state_d[j] = state_q[j];
            own_d[j]   = own_q[j];
            unique case (state_q[j])
                S_LOCK: begin
                    if (cand[j][own_q[j]]) begin
                        sel_d[j] = onehot(own_q[j]);
                        if (bus.tail[own_q[j]]) begin
                            state_d[j] = S_FREE;
                        end
                    end
                end
                S_FREE: begin
                    if (pick[j][3]) begin
                        sel_d[j] = onehot(pick[j][2:0]);
                        ptr_d[j] = wrap_inc(pick[j][2:0]);
                        if (!bus.tail[pick[j][2:0]]) begin
                            state_d[j] = S_LOCK;
                            own_d[j]   = pick[j][2:0];
                        end
                    end
                end
                default: state_d[j] = S_FREE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j < 5; j++) begin
                state_q[j] <= S_FREE;
                own_q[j]   <= '0;
            end
        end else begin
            for (int j = 0; j < 5; j++) begin
                state_q[j] <= state_d[j];
                own_q[j]   <= own_d[j];
            end
        end
    end

    always_comb begin
        for (int j = 0; j < 5; j++) begin
            busy_w[j] = (state_q[j] == S_LOCK);
        end
    end

    assign bus.busy = busy_w;
`else
    logic unused_tail;

    assign unused_tail = ^bus.tail;

    always_comb begin
        for (int j = 0; j < 5; j++) begin
            sel_d[j] = '0;
            ptr_d[j] = ptr_q[j];
            if (pick[j][3]) begin
                sel_d[j] = onehot(pick[j][2:0]);
                ptr_d[j] = wrap_inc(pick[j][2:0]);
            end
        end
    end

    assign bus.busy = 5'd0;
`endif

    always_comb begin
        gnt_d = '0;
        for (int j = 0; j < 5; j++) begin
            gnt_d = gnt_d | sel_d[j];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j < 5; j++) begin
                sel_q[j] <= '0;
                ptr_q[j] <= '0;
            end
            gnt_q <= '0;
        end else begin
            for (int j = 0; j < 5; j++) begin
                sel_q[j] <= sel_d[j];
                ptr_q[j] <= ptr_d[j];
            end
            gnt_q <= gnt_d;
        end
    end

    assign bus.sel0 = sel_q[0];
    assign bus.sel1 = sel_q[1];
    assign bus.sel2 = sel_q[2];
    assign bus.sel3 = sel_q[3];
    assign bus.sel4 = sel_q[4];
    assign bus.gnt  = gnt_q;
endmodule

// File: tb/tb_switch_allocator.sv
// Directed bench for switch_allocator; lock-dependent expectations follow
// SWALLOC_WORMHOLE_LOCK_EN.
module tb_switch_allocator;
    logic clk;
    logic rst;
    int   tests;
    int   fails;

    switch_allocator_if bus ();

    switch_allocator dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef SWALLOC_WORMHOLE_LOCK_EN
    localparam bit LOCK = 1'b1;
`else
    localparam bit LOCK = 1'b0;
`endif

    task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s got %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic drive(
        input logic [4:0] r0, input logic [4:0] r1, input logic [4:0] r2,
        input logic [4:0] r3, input logic [4:0] r4, input logic [4:0] t
    );
        bus.req0 = r0;
        bus.req1 = r1;
        bus.req2 = r2;
        bus.req3 = r3;
        bus.req4 = r4;
        bus.tail = t;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 5'b11111);
        step();
        rst = 1'b0;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst   = 1'b1;
        drive(0, 0, 0, 0, 0, 5'b11111);
        step();
        step();
        chk("rst_sel0", bus.sel0, 5'b00000);
        chk("rst_sel1", bus.sel1, 5'b00000);
        chk("rst_sel2", bus.sel2, 5'b00000);
        chk("rst_sel3", bus.sel3, 5'b00000);
        chk("rst_sel4", bus.sel4, 5'b00000);
        chk("rst_gnt", bus.gnt, 5'b00000);
        chk("rst_busy", bus.busy, 5'b00000);
        rst = 1'b0;

        step();
        chk("idle_sel2", bus.sel2, 5'b00000);
        chk("idle_gnt", bus.gnt, 5'b00000);

        // round robin on output 2
        drive(5'b00100, 5'b00100, 5'b00100, 0, 0, 5'b11111);
        step();
        chk("rr_sel2_a", bus.sel2, 5'b00001);
        chk("rr_gnt_a", bus.gnt, 5'b00001);
        step();
        chk("rr_sel2_b", bus.sel2, 5'b00010);
        chk("rr_gnt_b", bus.gnt, 5'b00010);
        step();
        chk("rr_sel2_c", bus.sel2, 5'b00100);
        chk("rr_gnt_c", bus.gnt, 5'b00100);
        chk("rr_busy", bus.busy, 5'b00000);

        // pointer wrap 4 -> 0
        do_reset();
        drive(0, 0, 0, 0, 5'b00001, 5'b11111);
        step();
        chk("wrap_sel0_a", bus.sel0, 5'b10000);
        chk("wrap_gnt_a", bus.gnt, 5'b10000);
        drive(5'b00001, 0, 0, 0, 5'b00001, 5'b11111);
        step();
        chk("wrap_sel0_b", bus.sel0, 5'b00001);
        chk("wrap_gnt_b", bus.gnt, 5'b00001);

        // malformed multi-hot request
        do_reset();
        drive(5'b00011, 0, 5'b00001, 0, 0, 5'b11111);
        step();
        chk("bad_sel0", bus.sel0, 5'b00100);
        chk("bad_sel1", bus.sel1, 5'b00000);
        chk("bad_gnt", bus.gnt, 5'b00100);

        // all inputs to distinct outputs
        do_reset();
        drive(5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b11111);
        step();
        chk("par_sel0", bus.sel0, 5'b00001);
        chk("par_sel1", bus.sel1, 5'b00010);
        chk("par_sel2", bus.sel2, 5'b00100);
        chk("par_sel3", bus.sel3, 5'b01000);
        chk("par_sel4", bus.sel4, 5'b10000);
        chk("par_gnt", bus.gnt, 5'b11111);

        // three-flit packet from input 1 to output 3, input 3 competing
        do_reset();
        drive(0, 5'b01000, 0, 5'b01000, 0, 5'b00000);
        step();
        chk("pkt_sel3_1", bus.sel3, 5'b00010);
        chk("pkt_busy_1", bus.busy, LOCK ? 5'b01000 : 5'b00000);
        step();
        chk("pkt_sel3_2", bus.sel3, LOCK ? 5'b00010 : 5'b01000);
        chk("pkt_busy_2", bus.busy, LOCK ? 5'b01000 : 5'b00000);
        drive(0, 5'b01000, 0, 5'b01000, 0, 5'b00010);
        step();
        chk("pkt_sel3_3", bus.sel3, 5'b00010);
        chk("pkt_gnt_3", bus.gnt, 5'b00010);
        chk("pkt_busy_3", bus.busy, 5'b00000);
        drive(0, 0, 0, 5'b01000, 0, 5'b00000);
        step();
        chk("pkt_sel3_4", bus.sel3, 5'b01000);
        chk("pkt_gnt_4", bus.gnt, 5'b01000);

        // reset while output 3 is locked
        do_reset();
        drive(0, 5'b01000, 0, 0, 0, 5'b00000);
        step();
        chk("mid_sel3", bus.sel3, 5'b00010);
        chk("mid_busy", bus.busy, LOCK ? 5'b01000 : 5'b00000);
        rst = 1'b1;
        step();
        chk("mid_rst_sel3", bus.sel3, 5'b00000);
        chk("mid_rst_busy", bus.busy, 5'b00000);
        rst = 1'b0;
        drive(0, 5'b01000, 5'b01000, 0, 0, 5'b11111);
        step();
        chk("post_sel3", bus.sel3, 5'b00010);
        chk("post_busy", bus.busy, 5'b00000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
